// File: rtl/life_engine.sv
// life_engine: in-place Conway generation update over a COLS x ROWS cell RAM.
// Define LIFE_WRAP_EN for a toroidal grid (LOAD then also reads the last row).
module life_engine #(
    parameter int COLS = 40,
    parameter int ROWS = 15,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic          busy,
    output logic          done,
    output logic [15:0]   gen_count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    // state | meaning
    // IDLE  | waiting for step, RAM port quiet
    // LOAD  | read row 0 (and row ROWS-1 when wrapping) into the buffers
    // FETCH | read row r+1 into row_next (last row: fill from row0 or zero)
    // WRITE | write the new state of row r, one cell per cycle
    // SHIFT | slide the three-row window down by one row
    // DONE  | one-cycle completion pulse, bump gen_count

    localparam int              CW         = $clog2(COLS + 1);
    localparam logic [3:0]      LAST_ROW   = 4'(ROWS - 1);
    localparam logic [CW-1:0]   CNT_RD_END = CW'(COLS);
    localparam logic [CW-1:0]   CNT_WR_END = CW'(COLS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, WRITE, SHIFT, DONE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cap_idx;
    logic [3:0]       r;
    logic             ld_ph;
    logic [COLS-1:0]  row_prev, row_cur, row_next;
`ifdef LIFE_WRAP_EN
    logic [COLS-1:0]  row0;
`endif
    logic [AW-1:0]    addr_hold, addr_c;
    logic             we_c;
    logic             rd_bit;
    logic [COLS+1:0]  ext_p, ext_c, ext_n;
    logic [2:0]       win_p, win_c, win_n;
    logic [3:0]       n_sum;
    logic             new_cell;

    function automatic logic [AW-1:0] cell_addr(input logic [3:0] row, input logic [CW-1:0] col);
        return AW'(COLS * int'(row) + int'(col));
    endfunction

    assign rd_bit  = |mem_rdata;
    assign cap_idx = cnt - CW'(1);

    // Padded rows: bit 0 is column -1, bit COLS+1 is column COLS.
`ifdef LIFE_WRAP_EN
    assign ext_p = {row_prev[0], row_prev, row_prev[COLS-1]};
    assign ext_c = {row_cur[0],  row_cur,  row_cur[COLS-1]};
    assign ext_n = {row_next[0], row_next, row_next[COLS-1]};
`else
    assign ext_p = {1'b0, row_prev, 1'b0};
    assign ext_c = {1'b0, row_cur,  1'b0};
    assign ext_n = {1'b0, row_next, 1'b0};
`endif

    assign win_p = ext_p[cnt +: 3];
    assign win_c = ext_c[cnt +: 3];
    assign win_n = ext_n[cnt +: 3];

    assign n_sum = 4'(win_p[0]) + 4'(win_p[1]) + 4'(win_p[2])
                 + 4'(win_c[0]) + 4'(win_c[2])
                 + 4'(win_n[0]) + 4'(win_n[1]) + 4'(win_n[2]);

    assign new_cell = (n_sum == 4'd3) | (win_c[1] & (n_sum == 4'd2));

    always_comb begin
        state_d = state;
        addr_c  = addr_hold;
        we_c    = 1'b0;
        case (state)
            IDLE: begin
                if (step) state_d = LOAD;
            end
            LOAD: begin
                if (cnt < CNT_RD_END) addr_c = cell_addr(ld_ph ? LAST_ROW : 4'd0, cnt);
                if (cnt == CNT_RD_END) begin
`ifdef LIFE_WRAP_EN
                    state_d = ld_ph ? FETCH : LOAD;
`else
                    state_d = FETCH;
`endif
                end
            end
            FETCH: begin
                if (r == LAST_ROW) begin
                    state_d = WRITE;
                end else begin
                    if (cnt < CNT_RD_END) addr_c = cell_addr(r + 4'd1, cnt);
                    if (cnt == CNT_RD_END) state_d = WRITE;
                end
            end
            WRITE: begin
                addr_c = cell_addr(r, cnt);
                we_c   = 1'b1;
                if (cnt == CNT_WR_END) state_d = SHIFT;
            end
            SHIFT: begin
                state_d = (r == LAST_ROW) ? DONE : FETCH;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            r         <= '0;
            ld_ph     <= 1'b0;
            row_prev  <= '0;
            row_cur   <= '0;
            row_next  <= '0;
`ifdef LIFE_WRAP_EN
            row0      <= '0;
`endif
            addr_hold <= '0;
            gen_count <= '0;
        end else begin
            state     <= state_d;
            addr_hold <= addr_c;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    r     <= '0;
                    ld_ph <= 1'b0;
                    if (step) row_prev <= '0;
                end
                LOAD: begin
                    // Data for the address issued last cycle arrives now.
                    if (cnt != '0) begin
                        if (ld_ph) begin
                            row_prev[cap_idx] <= rd_bit;
                        end else begin
                            row_cur[cap_idx] <= rd_bit;
`ifdef LIFE_WRAP_EN
                            row0[cap_idx]    <= rd_bit;
`endif
                        end
                    end
                    if (cnt == CNT_RD_END) begin
                        cnt   <= '0;
                        ld_ph <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FETCH: begin
                    if (r == LAST_ROW) begin
                        cnt <= '0;
`ifdef LIFE_WRAP_EN
                        row_next <= row0;
`else
                        row_next <= '0;
`endif
                    end else begin
                        if (cnt != '0) row_next[cap_idx] <= rd_bit;
                        cnt <= (cnt == CNT_RD_END) ? '0 : cnt + CW'(1);
                    end
                end
                WRITE: begin
                    cnt <= (cnt == CNT_WR_END) ? '0 : cnt + CW'(1);
                end
                SHIFT: begin
                    row_prev <= row_cur;
                    row_cur  <= row_next;
                    cnt      <= '0;
                    if (r != LAST_ROW) r <= r + 4'd1;
                end
                DONE: begin
                    gen_count <= gen_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign mem_addr  = addr_c;
    // A write must not land on the same edge that resets the engine.
    assign mem_we    = we_c & ~rst;
    assign mem_wdata = (state == WRITE) ? {7'd0, new_cell} : 8'h00;

endmodule
